// File: rtl/pe_dot_pipe.sv
// Pipelined LANES-wide signed inner-product PE with cross-beat accumulation and valid/ready output.
// Optional build macro PE_DOT_SAT_EN selects saturating tree conversion and accumulation.
module pe_dot_pipe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   neuron,
    input  logic [LANES*DW-1:0]   weight,
    input  logic [1:0]            ctrl,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic [ACC_W-1:0]      result,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic                  busy_o
);

    localparam int PW = 2 * DW;
    localparam int TW = PW + $clog2(LANES);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic en;
    logic accept;

    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic                 v1;
    logic [1:0]           c1;

    logic signed [TW-1:0] sum_d;
    logic signed [TW-1:0] s2_sum;
    logic                 v2;
    logic [1:0]           c2;

    logic [ACC_W-1:0]     tree;
    logic [ACC_W-1:0]     acc_add;
    logic [ACC_W-1:0]     psum_d;
    logic [ACC_W-1:0]     psum;

    logic [ACC_W-1:0]     s3_sum;
    logic                 v3;
    logic                 l3;
    logic                 vec_open;

    // One global enable: a stalled output freezes the whole pipe so nothing is lost.
    assign en     = !vld_o || rdy_i;
    assign rdy_o  = en;
    assign accept = vld_i && en;
    assign busy_o = v1 || v2 || v3 || vld_o || vec_open;

    always_comb begin
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        a = '0;
        b = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a         = neuron[i*DW +: DW];
            b         = weight[i*DW +: DW];
            prod_d[i] = PW'(a) * PW'(b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '{default: '0};
            v1     <= 1'b0;
            c1     <= '0;
        end else if (en) begin
            prod_q <= prod_d;
            v1     <= vld_i;
            c1     <= ctrl;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_d = sum_d + TW'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum <= '0;
            v2     <= 1'b0;
            c2     <= '0;
        end else if (en) begin
            s2_sum <= sum_d;
            v2     <= v1;
            c2     <= c1;
        end
    end

    generate
        if (ACC_W >= TW) begin : g_tree_ext
            always_comb tree = ACC_W'(s2_sum);
        end else begin : g_tree_narrow
`ifdef PE_DOT_SAT_EN
            // Value fits when all bits above the ACC_W sign bit replicate it.
            always_comb begin
                tree = s2_sum[ACC_W-1:0];
                if (!((s2_sum[TW-1:ACC_W-1] == '0) || (s2_sum[TW-1:ACC_W-1] == '1)))
                    tree = s2_sum[TW-1] ? ACC_MIN : ACC_MAX;
            end
`else
            logic unused_tree_hi;
            assign unused_tree_hi = ^s2_sum[TW-1:ACC_W];
            always_comb tree = s2_sum[ACC_W-1:0];
`endif
        end
    endgenerate

`ifdef PE_DOT_SAT_EN
    always_comb begin
        logic [ACC_W:0] sum_x;
        sum_x   = {psum[ACC_W-1], psum} + {tree[ACC_W-1], tree};
        acc_add = sum_x[ACC_W-1:0];
        if (sum_x[ACC_W] != sum_x[ACC_W-1])
            acc_add = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
    end
`else
    always_comb acc_add = psum + tree;
`endif

    assign psum_d = c2[0] ? tree : acc_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum   <= '0;
            s3_sum <= '0;
            v3     <= 1'b0;
            l3     <= 1'b0;
        end else if (en) begin
            v3 <= v2;
            l3 <= v2 && c2[1];
            if (v2) begin
                psum   <= psum_d;
                s3_sum <= psum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            vld_o  <= 1'b0;
        end else if (en) begin
            vld_o <= l3;
            if (l3)
                result <= s3_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_open <= 1'b0;
        end else if (accept) begin
            if (ctrl[1])
                vec_open <= 1'b0;
            else if (ctrl[0])
                vec_open <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_dot_pipe.sv
// Directed scoreboard bench for pe_dot_pipe: latency, multi-beat vectors, stall, saturation, reset.
module tb_pe_dot_pipe;

    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int ACC_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [LANES*DW-1:0] neuron;
    logic [LANES*DW-1:0] weight;
    logic [1:0]          ctrl;
    logic                vld_i;
    logic                rdy_o;
    logic [ACC_W-1:0]    result;
    logic                vld_o;
    logic                rdy_i;
    logic                busy_o;

    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [ACC_W-1:0] exp_q[$];
    int               xfer_cyc[$];

    pe_dot_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctrl   (ctrl),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .result (result),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every output transfer must match the oldest pending result.
    always @(negedge clk) begin
        #1;
        if (rst_n && vld_o && rdy_i) begin
            if (exp_q.size() == 0)
                chk("spurious_vld", ACC_W'(vld_o), '0);
            else
                chk("result", result, exp_q.pop_front());
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic drive(input int n, input int w, input logic [1:0] c);
        for (int i = 0; i < LANES; i++) begin
            neuron[i*DW +: DW] = DW'(n);
            weight[i*DW +: DW] = DW'(w);
        end
        ctrl = c;
    endtask

    task automatic beat(input int n, input int w, input logic [1:0] c, input logic [ACC_W-1:0] exp);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        drive(n, w, c);
        vld_i = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            #2;
            if (rdy_o) begin
                ok = 1'b1;
                if (c[1]) exp_q.push_back(exp);
            end
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        #1 vld_i = 1'b0;
        if (!ok) chk("accept_timeout", ACC_W'(ok), 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", ACC_W'(k < 200), 1);
    endtask

    logic [ACC_W-1:0] held;
    logic [ACC_W-1:0] sat_exp;

    initial begin
        rst_n = 1'b0;
        vld_i = 1'b0;
        rdy_i = 1'b1;
        drive(0, 0, 2'b00);
`ifdef PE_DOT_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h0000_0000;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vld_o", ACC_W'(vld_o), 0);
        chk("rst_result", result, 0);
        chk("rst_busy", ACC_W'(busy_o), 0);
        chk("rst_rdy_o", ACC_W'(rdy_o), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // One-beat vector and its exact latency.
        beat(1, 2, 2'b11, 64);
        chk("busy_inflight", ACC_W'(busy_o), 1);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat_edge_%0d", e - 1), ACC_W'(vld_o), (e == 4) ? 1 : 0);
        end
        drain();
        chk("idle_busy", ACC_W'(busy_o), 0);

        // Four-beat vector.
        beat(3, -1, 2'b01, 0);
        beat(3, -1, 2'b00, 0);
        beat(3, -1, 2'b00, 0);
        beat(3, -1, 2'b10, 32'hFFFF_FE80);
        drain();

        // Back-to-back one-beat then two-beat vector.
        beat(1, 2, 2'b01 | 2'b10, 64);
        beat(1, 1, 2'b01, 0);
        beat(1, 1, 2'b10, 64);
        drain();

        // Consecutive one-beat vectors give consecutive vld_o cycles.
        xfer_cyc.delete();
        beat(1, 2, 2'b11, 64);
        beat(1, 3, 2'b11, 96);
        drain();
        chk("xfer_count", ACC_W'(xfer_cyc.size()), 2);
        if (xfer_cyc.size() == 2)
            chk("consecutive", ACC_W'(xfer_cyc[1] - xfer_cyc[0]), 1);

        // New first beat discards an open partial sum.
        beat(3, -1, 2'b01, 0);
        beat(1, 2, 2'b11, 64);
        drain();

        // Downstream stall with several results pending and a beat waiting.
        @(negedge clk);
        rdy_i = 1'b0;
        beat(1, 2, 2'b11, 64);
        beat(1, 3, 2'b11, 96);
        beat(1, 1, 2'b11, 32);
        beat(2, 2, 2'b11, 128);
        fork
            beat(1, -1, 2'b11, 32'hFFFF_FFE0);
            begin
                chk("stall_vld_o", ACC_W'(vld_o), 1);
                held = result;
                chk("stall_first", held, 64);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_rdy_o", ACC_W'(rdy_o), 0);
                    chk("stall_result", result, held);
                end
                @(negedge clk);
                rdy_i = 1'b1;
            end
        join
        drain();

        // Overflowing tree sum of 2^33.
        beat(16'h4000, 16'h4000, 2'b11, sat_exp);
        drain();

        // Reset in the middle of a vector, then a clean restart.
        beat(3, -1, 2'b01, 0);
        beat(3, -1, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld_o", ACC_W'(vld_o), 0);
        chk("midrst_busy", ACC_W'(busy_o), 0);
        chk("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            #1;
            chk("no_stale_vld", ACC_W'(vld_o), 0);
        end
        beat(1, 2, 2'b11, 64);
        drain();

        chk("queue_empty", ACC_W'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
